// File: rtl/brick_pkg.sv
// brick_field shared types: command opcodes, FSM states, brick palette.
package brick_pkg;

    localparam logic [1:0] OP_INIT = 2'd0;
    localparam logic [1:0] OP_DRAW = 2'd1;
    localparam logic [1:0] OP_HIT  = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DRAW,
        S_LOOKUP,
        S_ERASE,
        S_DONE
    } state_e;

    // Palette index 1..7 so a live brick is never black.
    function automatic logic [2:0] colour_of(input int idx);
        return 3'((idx % 7) + 1);
    endfunction

endpackage

// File: rtl/brick_field_if.sv
// Command handshake from the game FSM and plot bus towards the VGA mux.
interface brick_field_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int IDX_W = 6
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [X_W-1:0]   cmd_x;
    logic [Y_W-1:0]   cmd_y;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [2:0]       colour;
    logic             plot;
    logic             busy;
    logic             done;
    logic             hit_valid;
    logic             hit;
    logic [IDX_W-1:0] hit_index;
    logic [IDX_W:0]   bricks_left;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y,
        input  cmd_ready, x, y, colour, plot, busy, done,
        input  hit_valid, hit, hit_index, bricks_left
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y,
        output cmd_ready, x, y, colour, plot, busy, done,
        output hit_valid, hit, hit_index, bricks_left
    );
endinterface

// File: rtl/brick_scan.sv
// Raster walker over one brick: row-major pixel coordinates from a loaded origin.
module brick_scan #(
    parameter int BRICK_W = 16,
    parameter int BRICK_H = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           step,
    input  logic [X_W-1:0] org_x,
    input  logic [Y_W-1:0] org_y,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);
    localparam int DX_W = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
    localparam int DY_W = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;
    localparam logic [DX_W-1:0] DX_LAST = DX_W'(BRICK_W - 1);
    localparam logic [DY_W-1:0] DY_LAST = DY_W'(BRICK_H - 1);

    logic [DX_W-1:0] dx_q, dx_d;
    logic [DY_W-1:0] dy_q, dy_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;

    // Absolute x/y are tracked directly so the plot bus comes straight from flops.
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        x_d  = x_q;
        y_d  = y_q;
        if (start) begin
            dx_d = '0;
            dy_d = '0;
            x_d  = org_x;
            y_d  = org_y;
        end else if (step) begin
            if (dx_q == DX_LAST) begin
                dx_d = '0;
                dy_d = dy_q + 1'b1;
                x_d  = x_q - X_W'(BRICK_W - 1);
                y_d  = y_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
                x_d  = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dx_q <= '0;
            dy_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (dx_q == DX_LAST) && (dy_q == DY_LAST);

endmodule

// File: rtl/brick_field.sv
// Brick wall engine: alive/colour state, wall rendering and ball hit resolution.
module brick_field
    import brick_pkg::*;
#(
    parameter int COLS      = 10,
    parameter int ROWS      = 4,
    parameter int BRICK_W   = 16,
    parameter int BRICK_H   = 4,
    parameter int ROW_PITCH = 8,
    parameter int ORIGIN_Y  = 0,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
) (
    input logic          clk,
    input logic          resetn,
    brick_field_if.slave bus
);
    localparam int N     = COLS * ROWS;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_CNT    = (IDX_W + 1)'(N);

    if (COLS * BRICK_W > (1 << X_W)) begin : g_x_range
        $error("brick_field: wall wider than the x coordinate range");
    end
    if (BRICK_H > ROW_PITCH) begin : g_h_range
        $error("brick_field: BRICK_H exceeds ROW_PITCH");
    end

    state_e           state_q, state_d;
    logic [N-1:0]     alive_q, alive_d;
    logic [IDX_W:0]   left_q, left_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
    logic [X_W-1:0]   cx_q, cx_d;
    logic [Y_W-1:0]   cy_q, cy_d;
    logic [2:0]       colour_q, colour_d;
    logic             hit_valid_q, hit_valid_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_index_q, hit_index_d;

    logic             scan_start, scan_step, scan_last;
    logic [IDX_W-1:0] scan_idx;
    logic [X_W-1:0]   org_x, pix_x;
    logic [Y_W-1:0]   org_y, pix_y;

    int               q_col, q_ry, q_row;
    logic             q_in, q_hit;
    logic [IDX_W-1:0] q_idx;

    function automatic logic [X_W-1:0] origin_x(input logic [IDX_W-1:0] b);
        return X_W'((int'(b) % COLS) * BRICK_W);
    endfunction

    function automatic logic [Y_W-1:0] origin_y(input logic [IDX_W-1:0] b);
        return Y_W'(ORIGIN_Y + (int'(b) / COLS) * ROW_PITCH);
    endfunction

    assign idx_nxt = idx_q + 1'b1;
    assign org_x   = origin_x(scan_idx);
    assign org_y   = origin_y(scan_idx);

    // Map the latched ball position onto a brick slot; rows have a gap below them.
    always_comb begin
        q_col = int'(cx_q) / BRICK_W;
        q_ry  = int'(cy_q) - ORIGIN_Y;
        q_row = q_ry / ROW_PITCH;
        q_in  = (q_ry >= 0) && (q_col < COLS) && (q_row < ROWS)
             && ((q_ry % ROW_PITCH) < BRICK_H);
        q_idx = q_in ? IDX_W'(q_row * COLS + q_col) : '0;
        q_hit = q_in && alive_q[q_idx];
    end

    always_comb begin
        state_d     = state_q;
        alive_d     = alive_q;
        left_d      = left_q;
        idx_d       = idx_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        colour_d    = colour_q;
        hit_valid_d = 1'b0;
        hit_d       = hit_q;
        hit_index_d = hit_index_q;
        scan_start  = 1'b0;
        scan_step   = 1'b0;
        scan_idx    = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cx_d = bus.cmd_x;
                    cy_d = bus.cmd_y;
                    unique case (bus.cmd_op)
                        OP_INIT: begin
                            state_d = S_INIT;
                            idx_d   = '0;
                        end
                        OP_DRAW: begin
                            state_d    = S_DRAW;
                            idx_d      = '0;
                            scan_start = 1'b1;
                            scan_idx   = '0;
                            colour_d   = alive_q[0] ? colour_of(0) : 3'd0;
                        end
                        OP_HIT:  state_d = S_LOOKUP;
                        OP_NOP:  state_d = S_DONE;
                    endcase
                end
            end
            S_INIT: begin
                alive_d[idx_q] = 1'b1;
                if (idx_q == LAST_IDX) begin
                    left_d  = N_CNT;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_nxt;
                end
            end
            S_DRAW: begin
                if (!scan_last) begin
                    scan_step = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d      = idx_nxt;
                    scan_start = 1'b1;
                    scan_idx   = idx_nxt;
                    colour_d   = alive_q[idx_nxt] ? colour_of(int'(idx_nxt)) : 3'd0;
                end
            end
            S_LOOKUP: begin
                hit_valid_d = 1'b1;
                hit_d       = q_hit;
                hit_index_d = q_hit ? q_idx : '0;
                if (q_hit) begin
                    alive_d[q_idx] = 1'b0;
                    left_d         = left_q - 1'b1;
                    idx_d          = q_idx;
                    scan_start     = 1'b1;
                    scan_idx       = q_idx;
                    colour_d       = 3'd0;
                    state_d        = S_ERASE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_ERASE: begin
                if (scan_last) state_d = S_DONE;
                else           scan_step = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            alive_q     <= '0;
            left_q      <= '0;
            idx_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            colour_q    <= '0;
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_index_q <= '0;
        end else begin
            state_q     <= state_d;
            alive_q     <= alive_d;
            left_q      <= left_d;
            idx_q       <= idx_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            colour_q    <= colour_d;
            hit_valid_q <= hit_valid_d;
            hit_q       <= hit_d;
            hit_index_q <= hit_index_d;
        end
    end

    brick_scan #(
        .BRICK_W (BRICK_W),
        .BRICK_H (BRICK_H),
        .X_W     (X_W),
        .Y_W     (Y_W)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .start  (scan_start),
        .step   (scan_step),
        .org_x  (org_x),
        .org_y  (org_y),
        .x      (pix_x),
        .y      (pix_y),
        .last   (scan_last)
    );

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.plot        = (state_q == S_DRAW) || (state_q == S_ERASE);
    assign bus.x           = pix_x;
    assign bus.y           = pix_y;
    assign bus.colour      = colour_q;
    assign bus.hit_valid   = hit_valid_q;
    assign bus.hit         = hit_q;
    assign bus.hit_index   = hit_index_q;
    assign bus.bricks_left = left_q;

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: expected pixels and hit results are queued per command.
module tb_brick_field;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    brick_field_if #(.X_W(8), .Y_W(7), .IDX_W(6)) bus();

    brick_field u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    pix_t pix_q[$];
    int   hit_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   plot_cnt = 0;
    int   done_cnt = 0;
    int   hv_cnt = 0;
    int   busy_cnt = 0;
    bit   mon_en = 1'b0;
    bit   alive_m[40];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push_brick(input int b);
        pix_t e;
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 16; dx++) begin
                e.x = 8'((b % 10) * 16 + dx);
                e.y = 7'((b / 10) * 8 + dy);
                e.c = alive_m[b] ? 3'((b % 7) + 1) : 3'd0;
                pix_q.push_back(e);
            end
        end
    endtask

    task automatic push_draw();
        for (int b = 0; b < 40; b++) push_brick(b);
    endtask

    task automatic run_cmd(input logic [1:0] op, input int cx, input int cy);
        int n;
        @(negedge clk);
        plot_cnt = 0;
        done_cnt = 0;
        hv_cnt = 0;
        busy_cnt = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_x = 8'(cx);
        bus.cmd_y = 7'(cy);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("cmd_timeout", int'(n < 5000), 1);
        @(negedge clk);
    endtask

    task automatic do_hit(input int cx, input int cy, input int exp_idx);
        int left0;
        left0 = int'(bus.bricks_left);
        if (exp_idx >= 0) begin
            hit_q.push_back(64 + exp_idx);
            alive_m[exp_idx] = 1'b0;
            push_brick(exp_idx);
        end else begin
            hit_q.push_back(0);
        end
        run_cmd(2'd2, cx, cy);
        check("hit_plots", plot_cnt, (exp_idx >= 0) ? 64 : 0);
        check("hit_valid_pulses", hv_cnt, 1);
        check("hit_left", int'(bus.bricks_left), (exp_idx >= 0) ? left0 - 1 : left0);
        check("hit_queue_drained", pix_q.size() + hit_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (bus.plot) begin
                plot_cnt++;
                if (pix_q.size() == 0) begin
                    check("plot_unexpected", 1, 0);
                end else begin
                    pix_t e, g;
                    e = pix_q.pop_front();
                    g = {bus.x, bus.y, bus.colour};
                    check("pixel_xyc", int'(g), int'(e));
                end
            end
            if (bus.hit_valid) begin
                hv_cnt++;
                if (hit_q.size() == 0) check("hit_unexpected", 1, 0);
                else check("hit_result", int'({bus.hit, bus.hit_index}), hit_q.pop_front());
            end
        end
    end

    initial begin
        int miss_x[3];
        int miss_y[3];
        miss_x = '{37, 37, 170};
        miss_y = '{13, 40, 2};
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'd0;
        bus.cmd_x = '0;
        bus.cmd_y = '0;
        for (int b = 0; b < 40; b++) alive_m[b] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", int'(bus.cmd_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_plot", int'(bus.plot), 0);
        check("rst_x", int'(bus.x), 0);
        check("rst_y", int'(bus.y), 0);
        check("rst_colour", int'(bus.colour), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_hit_valid", int'(bus.hit_valid), 0);
        check("rst_hit", int'(bus.hit), 0);
        check("rst_hit_index", int'(bus.hit_index), 0);
        check("rst_left", int'(bus.bricks_left), 0);
        resetn = 1'b1;
        mon_en = 1'b1;

        run_cmd(2'd0, 0, 0);
        for (int b = 0; b < 40; b++) alive_m[b] = 1'b1;
        check("init_done", done_cnt, 1);
        check("init_busy_cycles", busy_cnt, 41);
        check("init_plots", plot_cnt, 0);
        check("init_left", int'(bus.bricks_left), 40);

        push_draw();
        run_cmd(2'd1, 0, 0);
        check("draw_plots", plot_cnt, 2560);
        check("draw_done", done_cnt, 1);
        check("draw_queue", pix_q.size(), 0);

        do_hit(37, 10, 12);
        do_hit(37, 10, -1);
        for (int i = 0; i < 3; i++) do_hit(miss_x[i], miss_y[i], -1);
        do_hit(159, 27, 39);

        run_cmd(2'd3, 0, 0);
        check("nop_done", done_cnt, 1);
        check("nop_plots", plot_cnt, 0);
        check("nop_hit_valid", hv_cnt, 0);

        push_draw();
        run_cmd(2'd1, 0, 0);
        check("redraw_plots", plot_cnt, 2560);
        check("redraw_queue", pix_q.size(), 0);

        run_cmd(2'd0, 0, 0);
        for (int b = 0; b < 40; b++) alive_m[b] = 1'b1;
        check("rearm_left", int'(bus.bricks_left), 40);

        push_draw();
        @(negedge clk);
        plot_cnt = 0;
        done_cnt = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (999) @(negedge clk);
        #1;
        resetn = 1'b0;
        pix_q.delete();
        @(negedge clk);
        check("abort_plot", int'(bus.plot), 0);
        check("abort_left", int'(bus.bricks_left), 0);
        check("abort_plots_before", plot_cnt, 1000);
        resetn = 1'b1;
        @(negedge clk);
        check("abort_ready", int'(bus.cmd_ready), 1);
        check("abort_no_done", done_cnt, 0);
        for (int b = 0; b < 40; b++) alive_m[b] = 1'b0;

        push_draw();
        run_cmd(2'd1, 0, 0);
        check("dark_plots", plot_cnt, 2560);
        do_hit(37, 10, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/brick_field.md
Name: brick_field

Overview:
- Parametrised brick-wall engine for the 160x120 game: holds alive state and colour for a ROWS x COLS grid of bricks.
- Renders the wall pixel-by-pixel onto the vga_adapter plot interface.
- Resolves ball-position hit queries by clearing the hit brick and erasing it on screen.
- Sits between the game control FSM (command handshake) and the VGA plot mux.

Parameters:
- COLS, 10, bricks per row
- ROWS, 4, brick rows
- BRICK_W, 16, brick width in pixels; must be a power of 2
- BRICK_H, 4, brick height in pixels; must be <= ROW_PITCH
- ROW_PITCH, 8, vertical distance between row origins; must be a power of 2
- ORIGIN_Y, 0, y of row 0
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- Derived localparams: N = COLS*ROWS; IDX_W = clog2(N)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=INIT, 1=DRAW_ALL, 2=HIT, 3=reserved (accepted, no-op)
- cmd_x  in  X_W  HIT query x
- cmd_y  in  Y_W  HIT query y
- x  out  X_W  plot x
- y  out  Y_W  plot y
- colour  out  3  plot colour
- plot  out  1  pixel write enable
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse when a command completes
- hit_valid  out  1  one-cycle pulse with the HIT result
- hit  out  1  query landed on an alive brick
- hit_index  out  IDX_W  index of the hit brick (row*COLS+col)
- bricks_left  out  IDX_W+1  count of alive bricks

Behaviour:
- Reset: state IDLE; all alive bits 0; bricks_left=0; x=0, y=0, colour=0, plot=0, done=0, hit_valid=0, hit=0, hit_index=0.
- Reset mid-command aborts immediately; plot is 0 from the next cycle.
- Command accepted on posedge with cmd_valid && cmd_ready. cmd_x/cmd_y are latched at acceptance.
- Brick i geometry: row = i/COLS, col = i%COLS; origin (col*BRICK_W, ORIGIN_Y + row*ROW_PITCH); colour (i mod 7)+1, never 0.
- States: IDLE, INIT, DRAW, LOOKUP, ERASE, DONE.
- IDLE -> INIT / DRAW / LOOKUP according to cmd_op. Op 3 goes to DONE.
- INIT: sets one alive bit per cycle, index 0..N-1, in N cycles. bricks_left becomes N. No plotting. Then DONE.
- DRAW:
  - Walks bricks 0..N-1. Per brick it scans BRICK_W*BRICK_H pixels row-major: dx fastest, then dy.
  - plot=1 every cycle. x = origin_x+dx, y = origin_y+dy.
  - colour = brick colour if alive, else 0 (black).
  - The first pixel is registered in the cycle after acceptance. Exactly N*BRICK_W*BRICK_H plot cycles, then DONE.
- LOOKUP (1 cycle):
  - col = cmd_x / BRICK_W; ry = cmd_y - ORIGIN_Y; row = ry / ROW_PITCH.
  - Inside iff cmd_y >= ORIGIN_Y, col < COLS, row < ROWS, and ry mod ROW_PITCH < BRICK_H.
  - hit = inside && alive[idx]. hit_valid pulses at the end of LOOKUP with hit and hit_index. hit_index = 0 when hit = 0.
  - On hit: clear the alive bit, decrement bricks_left, go to ERASE. Otherwise go to DONE.
- ERASE: scans the hit brick's BRICK_W*BRICK_H pixels with colour 0 and plot=1, then DONE.
- DONE: done=1 for one cycle, cmd_ready=0, then IDLE.
- plot=0 in IDLE, INIT, LOOKUP and DONE.
- Arithmetic:
  - Pixel coordinates are computed at full width and truncated to X_W/Y_W.
  - A geometry that exceeds the screen is a configuration error; simulation asserts when COLS*BRICK_W > 2^X_W.
  - bricks_left never underflows: it is decremented only on hit, which requires an alive brick.
- HIT on an already-dead brick: hit=0, no erase, bricks_left unchanged.
- A second INIT while bricks remain re-arms every brick and sets bricks_left=N.

Decomposition:
- Shared package brick_pkg holds:
  - op encodings OP_INIT, OP_DRAW, OP_HIT, OP_NOP
  - the state enum
  - the colour function colour_of(idx)
- One natural sub-module, brick_scan:
  - start pulse loads the origin.
  - Emits dx/dy counters with a last flag after BRICK_W*BRICK_H cycles.
  - Used by both DRAW and ERASE.

Test Plan:
- Reset then INIT (defaults) -> busy for 40 cycles, then done, bricks_left=40; no plot during INIT.
- DRAW_ALL after INIT -> exactly 2560 plot cycles. First pixel (0,0) colour 1. Pixel 64 is (16,0) colour 2. Brick 10 starts at (0,8). Last pixel is (159,27) colour 5 (brick 39).
- HIT cmd_x=37, cmd_y=10 -> hit=1, hit_index=12. Then 64 black plots covering (32..47, 8..11). bricks_left=39.
- Repeat the same HIT -> hit=0, no plot, done; bricks_left stays 39. HIT at y=13 (gap row) or y=40 (below wall) -> hit=0.
- DRAW_ALL after the hit -> brick 12 pixels have colour 0, all others unchanged; still 2560 plots.
- Assert resetn for 1 cycle mid-DRAW (cycle 1000) -> plot=0 next cycle, bricks_left=0. cmd_ready=1 after release; no done pulse.
